galaksija_video_capture: RTL and testbench
==========================================

# galaksija_video_capture

Passive sink for the Galaksija video stream (`vga_dat`/`vga_hsync`/`vga_vsync`/`vga_blank`) sitting beside the video generator in the `clk` domain. It continuously measures incoming raster timing and, on request, captures one full frame as 1-bit-per-pixel data into an internal buffer. Host logic (OSD screenshot, self-test, bench scoreboard) reads the buffer out.

## Interface
Parameters:
- `CAP_W`, 320: captured pixels per line; a multiple of 8.
- `CAP_H`, 240: captured lines per frame.
- `THRESH`, 8'h80: a pixel is 1 when `vid_dat >= THRESH`.

Ports:
- `clk`  in  1  pixel clock; the same clock as the video generator.
- `reset`  in  1  synchronous, active-high reset.
- `vid_dat`  in  8  pixel data.
- `vid_hsync`  in  1  horizontal sync, active low.
- `vid_vsync`  in  1  vertical sync, active low.
- `vid_blank`  in  1  blanking, active high.
- `arm`  in  1  single-cycle capture request.
- `busy`  out  1  high while waiting for a frame or capturing.
- `done`  out  1  a frame has been captured; sticky.
- `lock`  out  1  the last two frames had identical `h_total` and `v_total`.
- `h_total`  out  10  clocks between the last two hsync assertions.
- `v_total`  out  10  hsync assertions between the last two vsync assertions.
- `h_active`  out  10  non-blank clocks on the last line that had any.
- `v_active`  out  10  lines that had non-blank pixels in the last frame.
- `rd_addr`  in  14  byte address into the buffer.
- `rd_data`  out  8  buffer byte; registered.

## Operation
- **Input stage:** all four video inputs are registered once. Edges are detected by comparing the registered value with the previous registered value.
  - hsync assertion (HS) = 1→0.
  - vsync assertion (VS) = 1→0.
  - Line start = blank 1→0.
  - Line end = blank 0→1.
- **Measurement (always running):**
  - `hcnt` counts clocks and restarts at HS; `h_total` is loaded with `hcnt + 1` at HS.
  - `lcnt` counts HS events and restarts at VS; `v_total` is loaded at VS.
  - `h_active` is loaded at line end.
  - `v_active` counts line ends per frame and is loaded at VS.
  - All counters saturate at 1023.
  - `lock` is set at VS when the new `h_total`/`v_total` equal the previous pair; otherwise it is cleared.
- **FSM states:** IDLE, WAIT_VS, CAPTURE, DONE.
  - IDLE --arm--> WAIT_VS.
  - WAIT_VS --VS--> CAPTURE. Pixel counters `x` and `y` are cleared.
  - CAPTURE --VS--> DONE.
  - DONE --arm--> WAIT_VS. `done` is cleared.
  - `arm` is ignored in WAIT_VS and CAPTURE.
  - `busy` = state is WAIT_VS or CAPTURE. `done` = state is DONE.
- **Capture:**
  - While CAPTURE and blank=0: the pixel bit is shifted into an 8-bit accumulator, first pixel at bit 7, and `x` increments.
  - `x` clears at line end; `y` increments at line end.
  - A byte is written when `x[2:0]` = 7, or at line end if the accumulator is partial (low bits zero-padded).
  - Write address = `y*(CAP_W/8) + x[9:3]`.
  - Writes with `x >= CAP_W` or `y >= CAP_H` are suppressed. Lines longer than `CAP_W` or frames taller than `CAP_H` are truncated without error.
- **Buffer:**
  - Depth is `CAP_W*CAP_H/8` (9600 at the defaults).
  - Reads at or beyond the depth return 8'h00.
  - The buffer is not cleared by reset or by `arm`; bytes never written keep their old contents.

## Timing
- **Reset values:**
  - FSM → IDLE.
  - `busy`, `done`, `lock` = 0.
  - All measurement outputs = 0.
  - `rd_data` = 0.
  - Reset mid-capture aborts the capture immediately.
- Input-to-edge latency is 2 clocks. Measurement outputs update 1 clock after the edge is detected.
- `busy` rises 1 clock after `arm`. `done` rises 1 clock after the terminating VS is detected.
- `rd_data` is valid 1 clock after `rd_addr`.
- A read and a write to the same address in the same clock return the old byte.
- VS and HS detected in the same clock: the HS is counted into the ending frame, then `lcnt` restarts at 0.
- Line end and a byte-complete event in the same clock produce a single write.

## Structure
- Package `galaksija_video_pkg` holds:
  - the FSM state enum;
  - the default raster constants: H_TOTAL 408, H_VISIBLE 320, V_TOTAL 262, V_VISIBLE 240;
  - a `CAP_BYTES` function.
- Sub-module `galaksija_capture_ram` is a simple dual-port RAM with a registered read port, one write port and one read port, both on `clk`.

## Test plan
- Drive the standard raster (408 × 262, 320 × 240 active) for 3 frames → `h_total` = 408, `v_total` = 262, `h_active` = 320, `v_active` = 240, `lock` = 1.
- `arm`, then drive a frame where pixel n of every line = (n mod 2 ? 8'hFF : 8'h00) → `done`; every byte 0..9599 reads 8'h55.
- Drive a 324-pixel active line with pixels 320..323 = 8'hFF → the byte at address 39 of that line is unaffected by pixels 320..323; no write beyond address 39 of that line.
- Drive a 10-pixel line of all 8'hFF → byte 0 = 8'hFF, byte 1 = 8'hC0.
- Pulse `arm` during CAPTURE → ignored; `done` follows the first VS after capture start. Assert `reset` mid-CAPTURE → `busy` = 0 next clock, `done` = 0.
- Change `h_total` to 400 for one frame → `lock` = 0 at the next VS, `lock` = 1 after two matching frames.

Source files
------------

// File: rtl/galaksija_video_pkg.sv
// Shared types and constants for the Galaksija video capture block.
//   cap_state_t : capture controller states
//   H_/V_ raster constants of the standard Galaksija picture
//   cap_bytes() : buffer depth in bytes for a given capture window
//   sat_inc()   : 10-bit saturating increment used by every counter
package galaksija_video_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WAIT_VS,
      ST_CAPTURE,
      ST_DONE
   } cap_state_t;

   localparam int H_TOTAL   = 408;
   localparam int H_VISIBLE = 320;
   localparam int V_TOTAL   = 262;
   localparam int V_VISIBLE = 240;

   function automatic int cap_bytes(input int w, input int h);
      return (w * h) / 8;
   endfunction

   function automatic logic [9:0] sat_inc(input logic [9:0] v);
      return (v == 10'h3FF) ? v : v + 10'd1;
   endfunction

endpackage

// File: rtl/galaksija_capture_ram.sv
// Simple dual-port byte RAM for the captured frame.
//   clk, reset         : clock; reset clears only the read register
//   we, wr_addr, wr_data : write port
//   rd_addr, rd_data   : read port, data registered one clock after address
// Reads at or beyond DEPTH return 8'h00. A read and a write to the same
// address in one clock return the old byte. Contents are never cleared.
module galaksija_capture_ram #(
   parameter int DEPTH = 9600,
   parameter int AW    = 14
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          we,
   input  logic [AW-1:0] wr_addr,
   input  logic [7:0]    wr_data,
   input  logic [AW-1:0] rd_addr,
   output logic [7:0]    rd_data
);

   localparam int IW = $clog2(DEPTH);

   logic [7:0] mem [0:DEPTH-1];

   always_ff @(posedge clk) begin
      if (we && (int'(wr_addr) < DEPTH))
         mem[wr_addr[IW-1:0]] <= wr_data;
   end

   always_ff @(posedge clk) begin
      if (reset)
         rd_data <= 8'h00;
      else if (int'(rd_addr) < DEPTH)
         rd_data <= mem[rd_addr[IW-1:0]];
      else
         rd_data <= 8'h00;
   end

endmodule

// File: rtl/galaksija_video_capture.sv
// Passive Galaksija video sink: measures raster timing continuously and
// captures one frame as 1 bit per pixel on request.
//   clk, reset                  : pixel clock, synchronous active-high reset
//   vid_dat/hsync/vsync/blank   : video stream (syncs active low, blank high)
//   arm, busy, done             : capture control
//   lock, h_total, v_total,
//   h_active, v_active          : raster measurements
//   rd_addr, rd_data            : buffer read port (1 clock latency)
// Control handshake: arm is a one-clock request honoured only in IDLE or
// DONE; busy goes high the next clock and stays high through WAIT_VS and
// CAPTURE; done is sticky from the clock after the terminating vsync until
// the next accepted arm or reset.
module galaksija_video_capture
   import galaksija_video_pkg::*;
#(
   parameter int         CAP_W  = H_VISIBLE,
   parameter int         CAP_H  = V_VISIBLE,
   parameter logic [7:0] THRESH = 8'h80
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [7:0]  vid_dat,
   input  logic        vid_hsync,
   input  logic        vid_vsync,
   input  logic        vid_blank,
   input  logic        arm,
   output logic        busy,
   output logic        done,
   output logic        lock,
   output logic [9:0]  h_total,
   output logic [9:0]  v_total,
   output logic [9:0]  h_active,
   output logic [9:0]  v_active,
   input  logic [13:0] rd_addr,
   output logic [7:0]  rd_data
);

   localparam int         DEPTH = cap_bytes(CAP_W, CAP_H);
   localparam logic [9:0] W_LIM = 10'(CAP_W);
   localparam logic [9:0] H_LIM = 10'(CAP_H);
   localparam logic [13:0] BPL  = 14'(CAP_W / 8);

   // input stage: one register, then a previous-value register for edges
   logic [7:0] dat_r;
   logic       hs_r, vs_r, blank_r;
   logic       hs_p, vs_p, blank_p;

   always_ff @(posedge clk) begin
      if (reset) begin
         dat_r   <= 8'h00;
         hs_r    <= 1'b1;
         vs_r    <= 1'b1;
         blank_r <= 1'b1;
         hs_p    <= 1'b1;
         vs_p    <= 1'b1;
         blank_p <= 1'b1;
      end else begin
         dat_r   <= vid_dat;
         hs_r    <= vid_hsync;
         vs_r    <= vid_vsync;
         blank_r <= vid_blank;
         hs_p    <= hs_r;
         vs_p    <= vs_r;
         blank_p <= blank_r;
      end
   end

   logic hs_ev, vs_ev, line_start, line_end, pix_bit;
   assign hs_ev      = hs_p & ~hs_r;
   assign vs_ev      = vs_p & ~vs_r;
   assign line_start = blank_p & ~blank_r;
   assign line_end   = ~blank_p & blank_r;
   assign pix_bit    = (dat_r >= THRESH);

   // measurement
   logic [9:0] hcnt, lcnt, acnt, vcnt, prev_h, prev_v;
   logic [9:0] h_new, v_new, va_new, h_cur;

   always_comb begin
      h_new  = sat_inc(hcnt);
      // an hsync coinciding with vsync still belongs to the ending frame
      v_new  = hs_ev ? sat_inc(lcnt) : lcnt;
      va_new = line_end ? sat_inc(vcnt) : vcnt;
      h_cur  = hs_ev ? h_new : h_total;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         hcnt     <= '0;
         lcnt     <= '0;
         acnt     <= '0;
         vcnt     <= '0;
         prev_h   <= '0;
         prev_v   <= '0;
         h_total  <= '0;
         v_total  <= '0;
         h_active <= '0;
         v_active <= '0;
         lock     <= 1'b0;
      end else begin
         hcnt <= hs_ev ? 10'd0 : h_new;
         if (hs_ev)
            h_total <= h_new;
         if (vs_ev) begin
            v_total  <= v_new;
            v_active <= va_new;
            lcnt     <= '0;
            vcnt     <= '0;
            lock     <= (h_cur == prev_h) && (v_new == prev_v);
            prev_h   <= h_cur;
            prev_v   <= v_new;
         end else begin
            lcnt <= v_new;
            vcnt <= va_new;
         end
         // the line-start clock already carries the first visible pixel
         if (line_start)
            acnt <= 10'd1;
         else if (!blank_r)
            acnt <= sat_inc(acnt);
         if (line_end)
            h_active <= acnt;
      end
   end

   // capture controller
   cap_state_t state;
   logic [9:0]  x, y;
   logic [7:0]  acc, pix_byte, wr_data;
   logic [13:0] wr_addr;
   logic        pix_en, byte_full, byte_part, we;

   always_comb begin
      pix_en    = (state == ST_CAPTURE) && !blank_r;
      byte_full = pix_en && (x[2:0] == 3'd7);
      // line end never carries a pixel, so it cannot collide with byte_full
      byte_part = (state == ST_CAPTURE) && line_end && (x[2:0] != 3'd0);
      pix_byte  = acc | (8'(pix_bit) << (3'd7 - x[2:0]));
      wr_data   = byte_full ? pix_byte : acc;
      wr_addr   = 14'(y) * BPL + 14'(x[9:3]);
      we        = (byte_full || byte_part) && (x < W_LIM) && (y < H_LIM);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= ST_IDLE;
         busy  <= 1'b0;
         done  <= 1'b0;
         x     <= '0;
         y     <= '0;
         acc   <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (arm) begin
                  state <= ST_WAIT_VS;
                  busy  <= 1'b1;
               end
            end
            ST_WAIT_VS: begin
               if (vs_ev) begin
                  state <= ST_CAPTURE;
                  x     <= '0;
                  y     <= '0;
                  acc   <= '0;
               end
            end
            ST_CAPTURE: begin
               if (vs_ev) begin
                  state <= ST_DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end else if (line_end) begin
                  x   <= '0;
                  y   <= sat_inc(y);
                  acc <= '0;
               end else if (pix_en) begin
                  x   <= sat_inc(x);
                  acc <= byte_full ? 8'h00 : pix_byte;
               end
            end
            ST_DONE: begin
               if (arm) begin
                  state <= ST_WAIT_VS;
                  busy  <= 1'b1;
                  done  <= 1'b0;
               end
            end
            default: begin
               state <= ST_IDLE;
               busy  <= 1'b0;
               done  <= 1'b0;
            end
         endcase
      end
   end

   galaksija_capture_ram #(
      .DEPTH (DEPTH),
      .AW    (14)
   ) u_ram (
      .clk     (clk),
      .reset   (reset),
      .we      (we),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .rd_addr (rd_addr),
      .rd_data (rd_data)
   );

endmodule

// File: tb/tb_galaksija_video_capture.sv
// Bench for galaksija_video_capture on a reduced raster (48 x 14 clocks,
// 32 x 8 visible) so that many frames fit in a short run.
module tb_galaksija_video_capture;
   import galaksija_video_pkg::*;

   localparam int         CW       = 32;
   localparam int         CH       = 8;
   localparam int         BPL      = CW / 8;
   localparam int         DEPTH    = CW * CH / 8;
   localparam int         HT       = 48;
   localparam int         HT_ALT   = 44;
   localparam int         VT       = 14;
   localparam int         HS_START = 38;
   localparam int         HS_W     = 4;
   localparam int         VS_LINE  = 10;
   localparam int         VS_LINES = 2;
   localparam logic [7:0] TH       = 8'h80;

   // clock / reset
   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   logic [7:0]  vid_dat;
   logic        vid_hsync, vid_vsync, vid_blank, arm;
   logic        busy, done, lock;
   logic [9:0]  h_total, v_total, h_active, v_active;
   logic [13:0] rd_addr;
   logic [7:0]  rd_data;

   galaksija_video_capture #(
      .CAP_W  (CW),
      .CAP_H  (CH),
      .THRESH (TH)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .vid_dat   (vid_dat),
      .vid_hsync (vid_hsync),
      .vid_vsync (vid_vsync),
      .vid_blank (vid_blank),
      .arm       (arm),
      .busy      (busy),
      .done      (done),
      .lock      (lock),
      .h_total   (h_total),
      .v_total   (v_total),
      .h_active  (h_active),
      .v_active  (v_active),
      .rd_addr   (rd_addr),
      .rd_data   (rd_data)
   );

   // scoreboard state
   logic [7:0] exp_mem [DEPTH];
   logic [7:0] exp_q [$];
   int n_checks = 0;
   int n_fail   = 0;
   bit aligned  = 1'b0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_idle();
      vid_dat   = 8'h00;
      vid_hsync = 1'b1;
      vid_vsync = 1'b1;
      vid_blank = 1'b1;
      arm       = 1'b0;
   endtask

   // vsync either starts at pixel 0 of its line or exactly with hsync
   function automatic bit vs_low(input int l, input int p);
      if (aligned)
         return (l == VS_LINE && p >= HS_START) ||
                (l > VS_LINE && l < VS_LINE + VS_LINES) ||
                (l == VS_LINE + VS_LINES && p < HS_START);
      return (l >= VS_LINE) && (l < VS_LINE + VS_LINES);
   endfunction

   // mode 0: alternating 00/FF; mode 1: random; mode 2: line 0 ten FF
   // pixels, line 1 36 pixels with FF beyond the window, rest random
   task automatic drive_span(input int htot, input int l0, input int l1,
                             input int mode, input bit cap, input int arm_line);
      for (int l = l0; l <= l1; l++) begin
         int         act;
         logic [7:0] v;
         logic [7:0] b;
         bit         bits [64];
         if (l >= CH)                    act = 0;
         else if (mode == 2 && l == 0)   act = 10;
         else if (mode == 2 && l == 1)   act = CW + 4;
         else                            act = CW;
         for (int p = 0; p < htot; p++) begin
            if (p >= act)                    v = 8'($urandom_range(0, 255));
            else if (mode == 2 && l == 0)    v = 8'hFF;
            else if (p >= CW)                v = 8'hFF;
            else if (mode == 0)              v = (p % 2 == 1) ? 8'hFF : 8'h00;
            else                             v = 8'($urandom_range(0, 255));
            bits[p]   = (p < act) && (v >= TH);
            vid_dat   = v;
            vid_blank = (p >= act);
            vid_hsync = !((p >= HS_START) && (p < HS_START + HS_W));
            vid_vsync = !vs_low(l, p);
            arm       = (l == arm_line) && (p == 0);
            tick();
         end
         if (cap && l < CH) begin
            for (int bi = 0; bi < BPL; bi++) begin
               if (bi * 8 < act) begin
                  b = 8'h00;
                  for (int i = 0; i < 8; i++) b[7-i] = bits[bi*8+i];
                  exp_mem[l*BPL+bi] = b;
               end
            end
         end
      end
      arm = 1'b0;
   endtask

   task automatic frame(input int htot, input int mode, input bit cap);
      drive_span(htot, 0, VT - 1, mode, cap, -1);
   endtask

   task automatic pulse_arm();
      arm = 1'b1;
      tick();
      arm = 1'b0;
   endtask

   task automatic read_check(input int a);
      rd_addr = 14'(a);
      exp_q.push_back((a < DEPTH) ? exp_mem[a] : 8'h00);
      tick();
      check_eq($sformatf("rd[%0d]", a), 32'(rd_data), 32'(exp_q.pop_front()));
   endtask

   task automatic read_const(input int a, input logic [7:0] exp);
      rd_addr = 14'(a);
      exp_q.push_back(exp);
      tick();
      check_eq($sformatf("rd_const[%0d]", a), 32'(rd_data), 32'(exp_q.pop_front()));
   endtask

   task automatic read_all();
      for (int a = 0; a < DEPTH; a++) read_check(a);
      read_check(DEPTH);
      read_check(16383);
   endtask

   task automatic check_meas(input string tag, input int ht, input int vt,
                             input int ha, input int va, input bit lk);
      check_eq({tag, ".h_total"},  32'(h_total),  32'(ht));
      check_eq({tag, ".v_total"},  32'(v_total),  32'(vt));
      check_eq({tag, ".h_active"}, 32'(h_active), 32'(ha));
      check_eq({tag, ".v_active"}, 32'(v_active), 32'(va));
      check_eq({tag, ".lock"},     32'(lock),     32'(lk));
   endtask

   initial begin
      #3_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      set_idle();
      rd_addr = 14'd0;
      reset   = 1'b1;
      repeat (3) tick();
      check_eq("rst.busy", 32'(busy), 32'd0);
      check_eq("rst.done", 32'(done), 32'd0);
      check_eq("rst.rd_data", 32'(rd_data), 32'd0);
      check_meas("rst", 0, 0, 0, 0, 1'b0);
      reset = 1'b0;
      tick();

      // free-running measurement on three standard frames
      aligned = 1'b0;
      repeat (3) frame(HT, 0, 1'b0);
      check_meas("std", HT, VT, CW, CH, 1'b1);
      check_eq("std.busy", 32'(busy), 32'd0);

      // capture 1: alternating pixels, arm pulses in WAIT_VS and CAPTURE
      pulse_arm();
      check_eq("arm1.busy", 32'(busy), 32'd1);
      check_eq("arm1.done", 32'(done), 32'd0);
      drive_span(HT, 0, VT - 1, 0, 1'b0, 3);
      check_eq("cap1.busy_start", 32'(busy), 32'd1);
      drive_span(HT, 0, VS_LINE - 1, 0, 1'b1, 3);
      check_eq("cap1.busy_pre_vs", 32'(busy), 32'd1);
      check_eq("cap1.done_pre_vs", 32'(done), 32'd0);
      drive_span(HT, VS_LINE, VT - 1, 0, 1'b1, -1);
      check_eq("cap1.done", 32'(done), 32'd1);
      check_eq("cap1.busy", 32'(busy), 32'd0);
      for (int a = 0; a < DEPTH; a++) read_const(a, 8'h55);
      read_const(DEPTH, 8'h00);

      // capture 2: short line, over-long line, random data
      pulse_arm();
      check_eq("arm2.busy", 32'(busy), 32'd1);
      check_eq("arm2.done", 32'(done), 32'd0);
      frame(HT, 1, 1'b0);
      frame(HT, 2, 1'b1);
      check_eq("cap2.done", 32'(done), 32'd1);
      check_meas("cap2", HT, VT, CW, CH, 1'b1);
      read_const(0, 8'hFF);
      read_const(1, 8'hC0);
      read_const(2, 8'h55);
      read_const(3, 8'h55);
      read_all();

      // capture 3: aborted by reset partway through the frame
      pulse_arm();
      frame(HT, 0, 1'b0);
      drive_span(HT, 0, 2, 0, 1'b1, -1);
      check_eq("cap3.busy", 32'(busy), 32'd1);
      reset = 1'b1;
      tick();
      check_eq("abort.busy", 32'(busy), 32'd0);
      check_eq("abort.done", 32'(done), 32'd0);
      check_eq("abort.h_total", 32'(h_total), 32'd0);
      check_eq("abort.lock", 32'(lock), 32'd0);
      reset = 1'b0;
      set_idle();
      tick();

      // lock tracking with vsync coinciding with hsync
      aligned = 1'b1;
      repeat (3) frame(HT, 0, 1'b0);
      check_meas("lk_a", HT, VT, CW, CH, 1'b1);
      frame(HT_ALT, 0, 1'b0);
      check_eq("lk_b.lock", 32'(lock), 32'd0);
      check_eq("lk_b.h_total", 32'(h_total), 32'(HT_ALT));
      check_eq("lk_b.v_total", 32'(v_total), 32'(VT));
      frame(HT, 0, 1'b0);
      check_eq("lk_c.lock", 32'(lock), 32'd0);
      frame(HT, 0, 1'b0);
      check_meas("lk_d", HT, VT, CW, CH, 1'b1);
      check_eq("lk_d.busy", 32'(busy), 32'd0);
      check_eq("lk_d.done", 32'(done), 32'd0);

      // buffer keeps rows from the aborted capture and older bytes
      read_all();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
